// File: rtl/cover_hit_collector_pkg.sv
// Shared types and constants for the cover-hit collector.
package cover_pkg;
   localparam int unsigned COVER_IDX_W         = 64;
   localparam int unsigned COVER_TOTAL_DEFAULT = 38253;

   typedef enum logic {RUN, DRAIN} cover_col_state_e;
endpackage

// File: rtl/cover_hit_collector_if.sv
// Ready/valid event stream carrying one global cover index per beat.
interface cover_hit_if;
   import cover_pkg::*;

   logic                   out_valid;
   logic                   out_ready;
   logic [COVER_IDX_W-1:0] out_index;

   modport master (output out_valid, output out_index, input out_ready);
   modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_hit_collector_lowest_set_index.sv
// Priority encoder: index and one-hot of the lowest set bit of vec_i.
module lowest_set_index #(
   parameter int W  = 15,
   parameter int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic [W-1:0]  onehot_o,
   output logic          any_o
);
   always_comb begin
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

   assign onehot_o = vec_i & (~vec_i + W'(1));
   assign any_o    = |vec_i;
endmodule

// File: rtl/cover_hit_collector.sv
// De-duplicates per-point hit strobes against a sticky covered bitmap and
// serializes each first-time hit as a global cover index on a ready/valid stream.
module cover_hit_collector
   import cover_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 15,
   parameter int unsigned COVER_INDEX = 0,
   parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [IN_WIDTH-1:0]           valid,
   input  logic                          clear_req,
   cover_hit_if.master                   out_if,
   output logic [$clog2(IN_WIDTH+1)-1:0] covered_count,
   output logic                          clear_done,
   output logic                          busy
);
   localparam int IW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int CW = $clog2(IN_WIDTH + 1);

   if (IN_WIDTH < 1 || IN_WIDTH > 64) begin : g_bad_width
      $error("cover_hit_collector: IN_WIDTH must be 1..64");
   end
   if (COVER_INDEX + IN_WIDTH > COVER_TOTAL) begin : g_bad_range
      $error("cover_hit_collector: COVER_INDEX + IN_WIDTH exceeds COVER_TOTAL");
   end

   cover_col_state_e      state_q;
   logic [IN_WIDTH-1:0]   covered_q, covered_d, pending_q, pending_d;
   logic [IN_WIDTH-1:0]   new_hits, pop, low_oh;
   logic [CW-1:0]         count_q, count_d;
   logic [IW-1:0]         low_idx;
   logic                  low_any, hs, drain_empty, done_q;

   lowest_set_index #(.W(IN_WIDTH), .IW(IW)) u_lsi (
      .vec_i    (pending_q),
      .idx_o    (low_idx),
      .onehot_o (low_oh),
      .any_o    (low_any)
   );

   always_comb begin
      new_hits    = valid & ~covered_q;
      hs          = low_any & out_if.out_ready;
      pop         = hs ? low_oh : '0;
      pending_d   = (pending_q & ~pop) | new_hits;
      covered_d   = covered_q | new_hits;
      count_d     = count_q + CW'(hs);
      // Exit test ignores this edge's new hits: they survive in pending_d.
      drain_empty = ((pending_q & ~pop) == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= RUN;
         covered_q <= '0;
         pending_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         covered_q <= covered_d;
         count_q   <= count_d;
         done_q    <= 1'b0;
         case (state_q)
            RUN: begin
               if (clear_req) begin
                  state_q <= DRAIN;
                  if (drain_empty) begin
                     covered_q <= '0;
                     count_q   <= '0;
                     done_q    <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // An empty-on-entry clear already finished; just return to RUN.
               if (done_q) begin
                  state_q <= RUN;
               end else if (drain_empty) begin
                  state_q   <= RUN;
                  covered_q <= '0;
                  count_q   <= '0;
                  done_q    <= 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign out_if.out_valid = low_any;
   assign out_if.out_index = COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(low_idx);
   assign covered_count    = count_q;
   assign clear_done       = done_q;
   assign busy             = (state_q == DRAIN);
endmodule

// File: tb/tb_cover_hit_collector.sv
// Directed self-checking bench for cover_hit_collector (COVER_INDEX = 100).
module tb_cover_hit_collector;
   logic        clock = 1'b0;
   logic        reset;
   logic [14:0] valid;
   logic        clear_req;
   logic [3:0]  covered_count;
   logic        clear_done, busy;
   int          checks = 0;
   int          errors = 0;

   cover_hit_if hit_if ();

   cover_hit_collector #(.IN_WIDTH(15), .COVER_INDEX(100), .COVER_TOTAL(38253)) dut (
      .clock         (clock),
      .reset         (reset),
      .valid         (valid),
      .clear_req     (clear_req),
      .out_if        (hit_if),
      .covered_count (covered_count),
      .clear_done    (clear_done),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; valid = '1; clear_req = 1'b0; hit_if.out_ready = 1'b0;
      tick(); chk("rst_vld0", hit_if.out_valid, 0); chk("rst_cnt0", covered_count, 0);
      tick(); chk("rst_vld1", hit_if.out_valid, 0); chk("rst_cnt1", covered_count, 0);
      chk("rst_idx", hit_if.out_index, 100);
      chk("rst_done", clear_done, 0); chk("rst_busy", busy, 0);
      reset = 1'b0; valid = '0;
      tick(); tick(); chk("post_rst_vld", hit_if.out_valid, 0);

      // single hit, then repeats are dropped
      hit_if.out_ready = 1'b1; valid = 15'h0004;
      tick(); chk("single_vld", hit_if.out_valid, 1); chk("single_idx", hit_if.out_index, 102);
      for (int r = 0; r < 5; r++) begin
         tick(); chk("repeat_vld", hit_if.out_valid, 0);
      end
      valid = '0;
      chk("single_cnt", covered_count, 1);

      // clear with nothing pending
      clear_req = 1'b1;
      tick(); chk("clr0_busy", busy, 1); chk("clr0_done", clear_done, 1); chk("clr0_cnt", covered_count, 0);
      clear_req = 1'b0;
      tick(); chk("clr0_busy_lo", busy, 0); chk("clr0_done_lo", clear_done, 0);

      // burst with 3-cycle stall
      hit_if.out_ready = 1'b0; valid = 15'h7FFF;
      tick(); valid = '0;
      for (int s = 0; s < 3; s++) begin
         chk("stall_idx", hit_if.out_index, 100); chk("stall_vld", hit_if.out_valid, 1);
         if (s < 2) tick();
      end
      hit_if.out_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         chk("burst_vld", hit_if.out_valid, 1); chk("burst_idx", hit_if.out_index, 64'(100 + k));
         tick();
      end
      chk("burst_end_vld", hit_if.out_valid, 0); chk("burst_cnt", covered_count, 15);

      // merge during stall
      clear_req = 1'b1; tick(); clear_req = 1'b0; hit_if.out_ready = 1'b0; tick();
      valid = 15'h0010; tick(); valid = 15'h0001; tick(); valid = '0;
      chk("merge_idx0", hit_if.out_index, 100);
      hit_if.out_ready = 1'b1;
      tick(); chk("merge_idx1", hit_if.out_index, 104);
      tick(); chk("merge_end", hit_if.out_valid, 0); chk("merge_cnt", covered_count, 2);

      // clear with 3 pending
      hit_if.out_ready = 1'b0; valid = 15'h000E; tick(); valid = '0;
      clear_req = 1'b1;
      tick(); chk("drain_busy", busy, 1); chk("drain_done0", clear_done, 0);
      chk("drain_idx0", hit_if.out_index, 101);
      clear_req = 1'b0; hit_if.out_ready = 1'b1;
      tick(); chk("drain_idx1", hit_if.out_index, 102); chk("drain_busy1", busy, 1);
      tick(); chk("drain_idx2", hit_if.out_index, 103); chk("drain_done1", clear_done, 0);
      tick(); chk("drain_done", clear_done, 1); chk("drain_cnt", covered_count, 0);
      chk("drain_busy_lo", busy, 0); chk("drain_vld", hit_if.out_valid, 0);
      valid = 15'h0004;
      tick(); chk("rehit_vld", hit_if.out_valid, 1); chk("rehit_idx", hit_if.out_index, 102);
      chk("rehit_done_lo", clear_done, 0);
      valid = '0;
      tick(); chk("rehit_cnt", covered_count, 1);

      // reset in the middle of a drain
      hit_if.out_ready = 1'b0; valid = 15'h0030; tick(); valid = '0;
      clear_req = 1'b1;
      tick(); chk("mid_busy", busy, 1); chk("mid_idx", hit_if.out_index, 104);
      clear_req = 1'b0; reset = 1'b1;
      tick(); chk("mid_vld", hit_if.out_valid, 0); chk("mid_ridx", hit_if.out_index, 100);
      chk("mid_cnt", covered_count, 0); chk("mid_done", clear_done, 0); chk("mid_rbusy", busy, 0);
      reset = 1'b0;
      tick(); chk("mid_done2", clear_done, 0); chk("mid_vld2", hit_if.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
